// File: rtl/mmio_controller.sv
// MMIO decode for the 0x8000_00xx window: UART TX/RX sequencing, cycle/instr counters; 1-cycle registered read data.
// Backpressure: a TX write while the slot is busy and not draining is dropped; RX pop is combinational with the load.
module mmio_controller #(
   parameter logic [3:0] MMIO_TOP = 4'h8
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Stall,
   input  logic [31:0] MemAddr,
   input  logic [31:0] MemWData,
   input  logic        MemRE,
   input  logic        MemWE,
   input  logic        InstrRetired,
   output logic        IsMMIO,
   output logic [31:0] RData,
   output logic [7:0]  DataIn,
   output logic        DataInValid,
   input  logic        DataInReady,
   input  logic [7:0]  DataOut,
   input  logic        DataOutValid,
   output logic        DataOutReady
);

   logic        top_match;
   logic        hit;
   logic        access;
   logic        load_hit;
   logic        store_hit;
   logic [7:0]  offset;
   logic        tx_free;
   logic        tx_accept;
   logic        cnt_clear;
   logic [31:0] rd_mux;
   logic [31:0] cycle_cnt;
   logic [31:0] instr_cnt;
   logic        unused_bits;

   assign top_match   = (MemAddr[31:28] == MMIO_TOP);
   assign hit         = top_match && !Stall;
   assign access      = (MemRE || MemWE) && !Stall;
   assign load_hit    = hit && MemRE;
   assign store_hit   = hit && MemWE;
   assign offset      = MemAddr[7:0];
   assign unused_bits = ^{MemAddr[27:8], MemWData[31:8]};

   assign tx_free   = DataInReady && !DataInValid;
   // A busy slot still takes a new byte when it drains on this same edge.
   assign tx_accept = store_hit && (offset == 8'h08) && (!DataInValid || DataInReady);
   assign cnt_clear = store_hit && (offset == 8'h18);

   // Pop is qualified by the current valid, so back-to-back reads never double pop.
   assign DataOutReady = !Reset && load_hit && (offset == 8'h04) && DataOutValid;

   always_comb begin
      rd_mux = '0;
      case (offset)
         8'h00:   rd_mux = {30'b0, DataOutValid, tx_free};
         8'h04:   rd_mux = DataOutValid ? {24'b0, DataOut} : 32'b0;
         8'h10:   rd_mux = cycle_cnt;
         8'h14:   rd_mux = instr_cnt;
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         IsMMIO      <= 1'b0;
         RData       <= '0;
         DataIn      <= '0;
         DataInValid <= 1'b0;
         cycle_cnt   <= '0;
         instr_cnt   <= '0;
      end else begin
         if (access) begin
            IsMMIO <= top_match;
            if (load_hit) RData <= rd_mux;
         end

         if (tx_accept) begin
            DataIn      <= MemWData[7:0];
            DataInValid <= 1'b1;
         end else if (DataInValid && DataInReady) begin
            DataInValid <= 1'b0;
         end

         // Clear wins over the same-edge increment.
         cycle_cnt <= cnt_clear ? 32'd0 : cycle_cnt + 32'd1;
         if (cnt_clear)
            instr_cnt <= '0;
         else if (InstrRetired)
            instr_cnt <= instr_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_mmio_controller.sv
// Randomized + directed bench for mmio_controller with a queue-based read scoreboard.
module tb_mmio_controller;

   logic        clk = 1'b0;
   logic        rst, stall, re, we, instr, rdy, dov;
   logic [31:0] addr, wdata;
   logic [7:0]  dout;
   logic        is_mmio, din_vld, dout_rdy;
   logic [31:0] rdata;
   logic [7:0]  din;

   mmio_controller #(.MMIO_TOP(4'h8)) dut (
      .Clock(clk), .Reset(rst), .Stall(stall), .MemAddr(addr), .MemWData(wdata),
      .MemRE(re), .MemWE(we), .InstrRetired(instr), .IsMMIO(is_mmio), .RData(rdata),
      .DataIn(din), .DataInValid(din_vld), .DataInReady(rdy), .DataOut(dout),
      .DataOutValid(dov), .DataOutReady(dout_rdy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic        ism;
      logic [31:0] rd;
      string       tag;
   } exp_t;

   exp_t        exp_q[$];
   int          cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;

   // Reference state: what software would observe of the block.
   logic [31:0] m_cyc, m_ins, m_rdata;
   logic        m_ism, m_txv;
   logic [7:0]  m_txd;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   // Monitor: compares registered read responses when they come due.
   always @(posedge clk) begin
      cyc++;
      #2;
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
         exp_t e;
         e = exp_q.pop_front();
         chk({e.tag, ".rdata"}, rdata, e.rd);
         chk({e.tag, ".ismmio"}, {31'b0, is_mmio}, {31'b0, e.ism});
      end
   end

   task automatic step(input logic r, input logic s, input logic ld, input logic st,
                       input logic [31:0] a, input logic [31:0] wd, input logic ry,
                       input logic dv, input logic [7:0] dd, input logic ir, input string tag);
      logic        top, h, exp_pop, done, acc, clr;
      logic [31:0] val;
      @(negedge clk);
      rst = r; stall = s; re = ld; we = st; addr = a; wdata = wd;
      rdy = ry; dov = dv; dout = dd; instr = ir;
      #1;
      top = (a[31:28] == 4'h8);
      h   = top && !s;
      exp_pop = !r && h && ld && (a[7:0] == 8'h04) && dv;
      chk({tag, ".pop"}, {31'b0, dout_rdy}, {31'b0, exp_pop});

      if (r) begin
         m_cyc = 0; m_ins = 0; m_rdata = 0; m_ism = 0; m_txv = 0; m_txd = 0;
      end else begin
         case (a[7:0])
            8'h00:   val = {30'b0, dv, ry && !m_txv};
            8'h04:   val = dv ? {24'b0, dd} : 32'b0;
            8'h10:   val = m_cyc;
            8'h14:   val = m_ins;
            default: val = 0;
         endcase
         if (h && ld) m_rdata = val;
         if ((ld || st) && !s) m_ism = top;
         done = m_txv && ry;
         acc  = h && st && (a[7:0] == 8'h08) && (!m_txv || ry);
         if (acc) begin
            m_txv = 1'b1;
            m_txd = wd[7:0];
         end else if (done) begin
            m_txv = 1'b0;
         end
         clr   = h && st && (a[7:0] == 8'h18);
         m_cyc = clr ? 32'd0 : m_cyc + 32'd1;
         m_ins = clr ? 32'd0 : m_ins + {31'b0, ir};
         if (ld) exp_q.push_back('{due: cyc + 1, ism: m_ism, rd: m_rdata, tag: tag});
      end

      @(posedge clk);
      #1;
      chk({tag, ".txvalid"}, {31'b0, din_vld}, {31'b0, m_txv});
      if (m_txv) chk({tag, ".txdata"}, {24'b0, din}, {24'b0, m_txd});
   endtask

   task automatic idle(input int n, input logic ry);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0, 0, ry, 0, 8'h0, 0, "idle");
   endtask

   localparam logic [31:0] MB = 32'h8000_0000;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] offs [8];
      offs = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h0C, 8'h20};
      m_cyc = 0; m_ins = 0; m_rdata = 0; m_ism = 0; m_txv = 0; m_txd = 0;

      // Reset, then check cleared outputs directly.
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst0");
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst1");
      chk("reset.rdata", rdata, 32'h0);
      chk("reset.ismmio", {31'b0, is_mmio}, 32'h0);

      // Reset abandons a pending TX byte.
      idle(2, 0);
      step(0, 0, 0, 1, MB | 32'h08, 32'h33, 0, 0, 0, 0, "tx_pre");
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_mid0");
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_mid1");
      chk("rst_mid.txvalid", {31'b0, din_vld}, 32'h0);
      idle(5, 0);
      step(0, 0, 1, 0, MB | 32'h10, 0, 0, 0, 0, 0, "cyc_after_rst");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "gap");
      chk("cyc_after_rst.value", rdata, 32'd5);

      // TX hold under no-ready, a dropped second write, then drain.
      step(0, 0, 0, 1, MB | 32'h08, 32'h41, 0, 0, 0, 0, "tx41");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "txhold1");
      step(0, 0, 0, 1, MB | 32'h08, 32'h42, 0, 0, 0, 0, "txdrop");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "txhold3");
      chk("txdrop.data", {24'b0, din}, 32'h41);
      step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "txdrain");
      chk("txdrain.valid", {31'b0, din_vld}, 32'h0);
      step(0, 0, 0, 1, MB | 32'h08, 32'h43, 1, 0, 0, 0, "txb2b0");
      step(0, 0, 0, 1, MB | 32'h08, 32'h44, 1, 0, 0, 0, "txb2b1");

      // RX pop, then empty read.
      step(0, 0, 1, 0, MB | 32'h04, 0, 1, 1, 8'h5A, 0, "rx5a");
      step(0, 0, 1, 0, MB | 32'h04, 0, 1, 0, 8'h77, 0, "rxempty");
      step(0, 0, 1, 0, MB | 32'h04, 0, 1, 1, 8'h11, 0, "rxb2b0");
      step(0, 0, 1, 0, MB | 32'h04, 0, 1, 1, 8'h22, 0, "rxb2b1");

      // Status idle and with TX pending.
      idle(2, 1);
      step(0, 0, 1, 0, MB, 0, 1, 1, 0, 0, "stat3");
      step(0, 0, 0, 1, MB | 32'h08, 32'h55, 0, 0, 0, 0, "txpend");
      step(0, 0, 1, 0, MB, 0, 1, 1, 0, 0, "stat2");

      // Counter clear beats a same-edge retire; cycle counter wrap.
      step(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, "ret0");
      step(0, 0, 0, 1, MB | 32'h18, 32'hDEAD, 1, 0, 0, 1, "clr");
      step(0, 0, 1, 0, MB | 32'h14, 0, 1, 0, 0, 1, "ins0");
      force dut.cycle_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.cycle_cnt;
      m_cyc = 32'hFFFF_FFFE;
      step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "wrap_pre");
      step(0, 0, 1, 0, MB | 32'h10, 0, 1, 0, 0, 0, "wrap_max");
      step(0, 0, 1, 0, MB | 32'h10, 0, 1, 0, 0, 0, "wrap_zero");

      // Stalled and non-MMIO loads.
      step(0, 0, 1, 0, MB | 32'h10, 0, 1, 0, 0, 0, "pre_stall");
      step(0, 1, 1, 0, MB | 32'h04, 0, 1, 1, 8'h99, 0, "stall_ld");
      step(0, 0, 1, 0, 32'h1000_0000, 0, 1, 1, 8'h99, 0, "nonmmio");

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         logic [31:0] a;
         int op;
         a  = MB | {24'b0, offs[$urandom_range(0, 7)]};
         if ($urandom_range(0, 7) == 0) a = {4'h1, a[27:0]};
         op = $urandom_range(0, 2);
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
              op == 1, op == 2, a, $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
              8'($urandom), $urandom_range(0, 1), "rand");
      end

      idle(3, 1);
      if (exp_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
